// File: rtl/mmx_rf_wb.sv
// MMX register file fed by an in-order writeback queue from alu3, with a priority load port and mm1/mm2 reads.
// Define MMX_WB_BYPASS_EN to forward queued results to the read ports; otherwise mm_busy reports read hazards.
module mmx_rf_wb #(
  parameter int DEPTH = 2,
  parameter int NREG  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_v,
  output logic        wb_rdy,
  input  logic [4:0]  wb_op,
  input  logic [2:0]  wb_dst,
  input  logic [63:0] alu_res3,
  input  logic        ld_we,
  input  logic [2:0]  ld_dst,
  input  logic [63:0] ld_wdata,
  input  logic [2:0]  rd1_idx,
  input  logic [2:0]  rd2_idx,
  output logic [63:0] mm1,
  output logic [63:0] mm2,
  output logic        mm_busy,
  output logic        ecx_we,
  output logic [31:0] ecx_wdata
);
  // Handshake: a result transfers on an edge where wb_v && wb_rdy; while wb_v && !wb_rdy the
  // producer holds wb_op/wb_dst/alu_res3 stable. wb_rdy never depends on wb_v.

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [4:0] OP_ECX = 5'b11000;

  logic [63:0]      rf_q     [NREG];
  logic [4:0]       q_op_q   [DEPTH];
  logic [2:0]       q_dst_q  [DEPTH];
  logic [63:0]      q_data_q [DEPTH];
  logic [DEPTH-1:0] q_live_q;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          ecx_we_q, ecx_we_d;
  logic [31:0]   ecx_wdata_q, ecx_wdata_d;

  logic [PW-1:0]    count;
  logic [AW-1:0]    wr_slot, rd_slot;
  logic             empty, full, push, pop;
  logic             hd_live, hd_ecx, push_ecx, push_live;
  logic             commit_mmx, commit_ecx;
  logic [AW-1:0]    age_slot [DEPTH];
  logic [DEPTH-1:0] occ, mmx_live, kill;

  assign wr_slot  = wr_ptr_q[AW-1:0];
  assign rd_slot  = rd_ptr_q[AW-1:0];
  assign count    = wr_ptr_q - rd_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_slot == rd_slot);
  assign wb_rdy   = ~full;
  assign push     = wb_v && !full;
  // The load port owns the rf write port, so the head waits out every ld_we cycle.
  assign pop      = !empty && !ld_we;

  assign hd_live    = q_live_q[rd_slot];
  assign hd_ecx     = (q_op_q[rd_slot] == OP_ECX);
  assign commit_mmx = pop && hd_live && !hd_ecx;
  assign commit_ecx = pop && hd_live && hd_ecx;

  // A same-edge load to the same register is younger, so the new entry is born dead.
  assign push_ecx  = (wb_op == OP_ECX);
  assign push_live = !(ld_we && !push_ecx && (wb_dst == ld_dst));

  always_comb begin
    occ      = '0;
    mmx_live = '0;
    kill     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      age_slot[k] = rd_slot + AW'(k);
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (PW'(k) < count) occ[age_slot[k]] = 1'b1;
    end
    for (int s = 0; s < DEPTH; s++) begin
      mmx_live[s] = occ[s] && q_live_q[s] && (q_op_q[s] != OP_ECX);
      kill[s]     = ld_we && (q_op_q[s] != OP_ECX) && (q_dst_q[s] == ld_dst);
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ecx_we_d    = 1'b0;
    ecx_wdata_d = ecx_wdata_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (commit_ecx) begin
      ecx_we_d    = 1'b1;
      ecx_wdata_d = q_data_q[rd_slot][31:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      q_live_q    <= '0;
      ecx_we_q    <= 1'b0;
      ecx_wdata_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
      for (int s = 0; s < DEPTH; s++) begin
        q_op_q[s]   <= '0;
        q_dst_q[s]  <= '0;
        q_data_q[s] <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ecx_we_q    <= ecx_we_d;
      ecx_wdata_q <= ecx_wdata_d;
      for (int s = 0; s < DEPTH; s++) begin
        if (kill[s]) q_live_q[s] <= 1'b0;
      end
      // Placed after the kill loop so a fresh push overrides a stale kill of its slot.
      if (push) begin
        q_op_q[wr_slot]   <= wb_op;
        q_dst_q[wr_slot]  <= wb_dst;
        q_data_q[wr_slot] <= alu_res3;
        q_live_q[wr_slot] <= push_live;
      end
      if (ld_we) begin
        rf_q[ld_dst] <= ld_wdata;
      end else if (commit_mmx) begin
        rf_q[q_dst_q[rd_slot]] <= q_data_q[rd_slot];
      end
    end
  end

  assign ecx_we    = ecx_we_q;
  assign ecx_wdata = ecx_wdata_q;

`ifdef MMX_WB_BYPASS_EN
  // Walk entries oldest to youngest so the youngest match wins; the load port beats everything.
  always_comb begin
    mm1     = rf_q[rd1_idx];
    mm2     = rf_q[rd2_idx];
    mm_busy = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (mmx_live[age_slot[k]] && (q_dst_q[age_slot[k]] == rd1_idx)) mm1 = q_data_q[age_slot[k]];
      if (mmx_live[age_slot[k]] && (q_dst_q[age_slot[k]] == rd2_idx)) mm2 = q_data_q[age_slot[k]];
    end
    if (ld_we && (ld_dst == rd1_idx)) mm1 = ld_wdata;
    if (ld_we && (ld_dst == rd2_idx)) mm2 = ld_wdata;
  end
`else
  always_comb begin
    mm1     = (ld_we && (ld_dst == rd1_idx)) ? ld_wdata : rf_q[rd1_idx];
    mm2     = (ld_we && (ld_dst == rd2_idx)) ? ld_wdata : rf_q[rd2_idx];
    mm_busy = 1'b0;
    for (int s = 0; s < DEPTH; s++) begin
      if (mmx_live[s] && ((q_dst_q[s] == rd1_idx) || (q_dst_q[s] == rd2_idx))) mm_busy = 1'b1;
    end
  end
`endif

endmodule
